// File: rtl/digit_serial_addsub.sv
// Digit-serial adder/subtractor: processes a WIDTH-bit operand pair DIGIT bits per
// clock, LSB digit first, with a start/busy/done handshake and signed-overflow flag.
// Subtraction is a + ~b + ~cin, so cout=1 means "no borrow".
module digit_serial_addsub #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DIGIT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NDIG = WIDTH / DIGIT;
    localparam int unsigned CntW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(NDIG - 1);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [CntW-1:0]  cnt_q;

    logic [DIGIT:0]   dsum;
    logic             carry_into_msb;
    logic [WIDTH-1:0] res_d;

    // Per-digit adder and carry into the top bit of the current digit
    always_comb begin
        dsum = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
        // Only meaningful on the last digit, where bit DIGIT-1 is bit WIDTH-1
        carry_into_msb = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ dsum[DIGIT-1];
    end

    // Result accumulator holds the previously completed digits; the current digit is
    // spliced on top so the full result is available on the final RUN edge.
    generate
        if (NDIG > 1) begin : g_shift
            logic [WIDTH-1:DIGIT] acc_q;

            assign res_d = {dsum[DIGIT-1:0], acc_q};

            // Shift each finished digit into the top of the accumulator
            always_ff @(posedge clk) begin
                if (rst) begin
                    acc_q <= '0;
                end else if (state_q == StRun) begin
                    acc_q <= res_d[WIDTH-1:DIGIT];
                end
            end
        end else begin : g_single
            assign res_d = dsum[DIGIT-1:0];
        end
    endgenerate

    // Control FSM, operand shifters, carry and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= sub ? ~b : b;
                        carry_q <= cin ^ sub;
                        cnt_q   <= '0;
                        busy    <= 1'b1;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    a_q     <= a_q >> DIGIT;
                    b_q     <= b_q >> DIGIT;
                    carry_q <= dsum[DIGIT];
                    cnt_q   <= cnt_q + CntW'(1);
                    if (cnt_q == LastCnt) begin
                        sum     <= res_d;
                        cout    <= dsum[DIGIT];
                        ovf     <= carry_into_msb ^ dsum[DIGIT];
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_digit_serial_addsub.sv
// Self-checking bench for digit_serial_addsub: four configurations (64/8, 16/1,
// 16/4, 16/16) share stimulus and are checked against an arithmetic model.
module tb_digit_serial_addsub;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sub;
    logic        cin;
    logic [63:0] a;
    logic [63:0] b;

    logic        busy [4];
    logic        done [4];
    logic        cout [4];
    logic        ovf  [4];
    logic [63:0] sum0;
    logic [15:0] s16 [1:3];

    int n_checks = 0;
    int n_errors = 0;
    logic [63:0] last_sum;

    localparam int LatExp [4] = '{8, 16, 4, 1};

    always #5 clk = ~clk;

    digit_serial_addsub #(.WIDTH(64), .DIGIT(8)) u_d64_8 (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy[0]), .done(done[0]), .sum(sum0), .cout(cout[0]), .ovf(ovf[0])
    );
    digit_serial_addsub #(.WIDTH(16), .DIGIT(1)) u_d16_1 (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a[15:0]), .b(b[15:0]), .cin(cin),
        .busy(busy[1]), .done(done[1]), .sum(s16[1]), .cout(cout[1]), .ovf(ovf[1])
    );
    digit_serial_addsub #(.WIDTH(16), .DIGIT(4)) u_d16_4 (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a[15:0]), .b(b[15:0]), .cin(cin),
        .busy(busy[2]), .done(done[2]), .sum(s16[2]), .cout(cout[2]), .ovf(ovf[2])
    );
    digit_serial_addsub #(.WIDTH(16), .DIGIT(16)) u_d16_16 (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a[15:0]), .b(b[15:0]), .cin(cin),
        .busy(busy[3]), .done(done[3]), .sum(s16[3]), .cout(cout[3]), .ovf(ovf[3])
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] sum_of(input int i);
        return (i == 0) ? sum0 : {48'd0, s16[i]};
    endfunction

    // Reference: exact integer arithmetic on w-bit operands; returns {ovf, cout, sum}
    function automatic logic [65:0] model(input int w, input logic [63:0] av,
                                          input logic [63:0] bv, input logic sv,
                                          input logic cv);
        logic signed [129:0] one, modv, lim, ua, ub, ci, t, tm, sa, sb, ex;
        logic co, ov;
        one  = 1;
        modv = one <<< w;
        lim  = one <<< (w - 1);
        ua = '0; ua[63:0] = av; ua = ua & (modv - one);
        ub = '0; ub[63:0] = bv; ub = ub & (modv - one);
        ci = '0; ci[0] = cv;
        t  = sv ? (ua - ub - ci) : (ua + ub + ci);
        tm = t & (modv - one);
        co = sv ? (t >= 0) : (t >= modv);
        sa = (ua >= lim) ? ua - modv : ua;
        sb = (ub >= lim) ? ub - modv : ub;
        ex = sv ? (sa - sb - ci) : (sa + sb + ci);
        ov = (ex >= lim) || (ex < -lim);
        return {ov, co, tm[63:0]};
    endfunction

    function automatic logic any_busy();
        return busy[0] | busy[1] | busy[2] | busy[3];
    endfunction

    task automatic wait_idle();
        int t = 0;
        while (any_busy() && t < 60) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 60) check("idle_timeout", {63'd0, any_busy()}, 64'd0);
    endtask

    function automatic logic [63:0] rand64();
        case ($urandom_range(0, 5))
            0:       return 64'hFFFF_FFFF_FFFF_FFFF;
            1:       return 64'h8000_0000_0000_8000;
            2:       return 64'h7FFF_FFFF_FFFF_7FFF;
            3:       return {32'd0, 16'd0, 16'($urandom_range(0, 3))};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // One operation on all four configurations; checks latency, busy/done and results
    task automatic run_op(input logic [63:0] av, input logic [63:0] bv,
                          input logic sv, input logic cv);
        int          lat [4];
        logic [63:0] got_s [4];
        logic        got_c [4];
        logic        got_o [4];
        logic [65:0] e;
        int          busy_n;
        int          done_n;
        wait_idle();
        a = av; b = bv; sub = sv; cin = cv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // Inputs changing while busy must have no effect
        a = {$urandom, $urandom}; b = {$urandom, $urandom};
        sub = 1'($urandom); cin = 1'($urandom);
        for (int i = 0; i < 4; i++) begin
            lat[i] = 0; got_s[i] = '0; got_c[i] = 1'b0; got_o[i] = 1'b0;
        end
        busy_n = busy[0] ? 1 : 0;
        done_n = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (busy[0]) busy_n++;
            if (done[0]) done_n++;
            for (int i = 0; i < 4; i++) begin
                if (done[i] && lat[i] == 0) begin
                    lat[i]   = k;
                    got_s[i] = sum_of(i);
                    got_c[i] = cout[i];
                    got_o[i] = ovf[i];
                end
            end
        end
        check("busy_cycles", busy_n, 8);
        check("done_width", done_n, 1);
        for (int i = 0; i < 4; i++) begin
            e = model((i == 0) ? 64 : 16, av, bv, sv, cv);
            check($sformatf("latency[%0d]", i), lat[i], LatExp[i]);
            check($sformatf("sum[%0d]", i), got_s[i], e[63:0]);
            check($sformatf("cout[%0d]", i), {63'd0, got_c[i]}, {63'd0, e[64]});
            check($sformatf("ovf[%0d]", i), {63'd0, got_o[i]}, {63'd0, e[65]});
            if (i == 0) last_sum = e[63:0];
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] ha [2];
        logic [63:0] hb [2];
        logic        hs [2];
        logic [65:0] e;
        logic [63:0] prev;
        int          dcnt;

        rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {63'd0, busy[0]}, 64'd0);
        check("rst_done", {63'd0, done[0]}, 64'd0);
        check("rst_sum", sum0, 64'd0);
        check("rst_cout", {63'd0, cout[0]}, 64'd0);
        check("rst_ovf", {63'd0, ovf[0]}, 64'd0);
        rst = 1'b0;

        // Directed cases with hand-derived expectations
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
        check("wrap_sum", sum0, 64'd0);
        check("wrap_cout", {63'd0, cout[0]}, 64'd1);
        check("wrap_ovf", {63'd0, ovf[0]}, 64'd0);
        run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
        check("addovf_sum", sum0, 64'h8000_0000_0000_0000);
        check("addovf_cout", {63'd0, cout[0]}, 64'd0);
        check("addovf_ovf", {63'd0, ovf[0]}, 64'd1);
        run_op(64'd5, 64'd7, 1'b1, 1'b0);
        check("sub_neg_sum", sum0, 64'hFFFF_FFFF_FFFF_FFFE);
        check("sub_neg_cout", {63'd0, cout[0]}, 64'd0);
        check("sub_neg_ovf", {63'd0, ovf[0]}, 64'd0);
        run_op(64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b0);
        check("subovf_sum", sum0, 64'h7FFF_FFFF_FFFF_FFFF);
        check("subovf_cout", {63'd0, cout[0]}, 64'd1);
        check("subovf_ovf", {63'd0, ovf[0]}, 64'd1);
        run_op(64'd10, 64'd3, 1'b1, 1'b1);
        check("borrow_sum", sum0, 64'd6);
        check("borrow_cout", {63'd0, cout[0]}, 64'd1);

        // Back-to-back with start held high and alternating operands
        ha[0] = {$urandom, $urandom}; hb[0] = {$urandom, $urandom}; hs[0] = 1'b0;
        ha[1] = {$urandom, $urandom}; hb[1] = {$urandom, $urandom}; hs[1] = 1'b1;
        wait_idle();
        prev = last_sum;
        a = ha[0]; b = hb[0]; sub = hs[0]; cin = 1'b0; start = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(posedge clk); #1;
            a = ha[(j + 1) % 2]; b = hb[(j + 1) % 2]; sub = hs[(j + 1) % 2];
            e = model(64, ha[j % 2], hb[j % 2], hs[j % 2], 1'b0);
            for (int k = 1; k <= 8; k++) begin
                @(posedge clk); #1;
                if (k == 4) begin
                    check("hs_sum_held", sum0, prev);
                    check("hs_busy", {63'd0, busy[0]}, 64'd1);
                end
                if (k == 7) check("hs_no_early_done", {63'd0, done[0]}, 64'd0);
                if (k == 8) begin
                    check("hs_done", {63'd0, done[0]}, 64'd1);
                    check("hs_idle", {63'd0, busy[0]}, 64'd0);
                    check("hs_sum", sum0, e[63:0]);
                end
            end
            prev = e[63:0];
        end
        start = 1'b0;

        // Reset in the 4th RUN cycle aborts with no done pulse
        wait_idle();
        a = {$urandom, $urandom}; b = {$urandom, $urandom}; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_busy", {63'd0, busy[0]}, 64'd0);
        check("abort_done", {63'd0, done[0]}, 64'd0);
        check("abort_sum", sum0, 64'd0);
        check("abort_cout", {63'd0, cout[0]}, 64'd0);
        check("abort_ovf", {63'd0, ovf[0]}, 64'd0);
        rst = 1'b0;
        dcnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (done[0]) dcnt++;
        end
        check("abort_no_done", dcnt, 0);
        run_op(64'h0123_4567_89AB_CDEF, 64'h1111_2222_3333_4444, 1'b0, 1'b1);

        // Randomised sweep across all configurations
        for (int n = 0; n < 1000; n++) begin
            run_op(rand64(), rand64(), 1'($urandom), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/digit_serial_addsub.md
Name: digit_serial_addsub

Overview:
- Parametrised sequential adder/subtractor that processes a WIDTH-bit operand pair DIGIT bits per clock, LSB digit first, carrying between digits in a register.
- Trades latency (WIDTH/DIGIT cycles) for area relative to the fully combinational ripple adders.
- Adds a start/busy/done handshake, a subtract mode and signed-overflow detection.
- Used wherever an arithmetic datapath can tolerate multi-cycle latency.

Parameters:
- WIDTH, 64, operand and result width in bits; must be a multiple of DIGIT.
- DIGIT, 8, bits processed per cycle; 1 <= DIGIT <= WIDTH. Number of digits NDIG = WIDTH/DIGIT.

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request a new operation; sampled only when busy=0
- sub  in  1  0 = add (a+b+cin); 1 = subtract (a-b-cin, cin acts as borrow-in)
- a  in  WIDTH  operand A, sampled on the accepting edge only
- b  in  WIDTH  operand B, sampled on the accepting edge only
- cin  in  1  carry-in (add) or borrow-in (sub), sampled on the accepting edge
- busy  out  1  high while an operation is in progress
- done  out  1  one-cycle pulse when sum/cout/ovf are updated
- sum  out  WIDTH  result, held stable between done pulses
- cout  out  1  final carry out; in subtract mode 1 = no borrow, 0 = borrow
- ovf  out  1  two's-complement signed overflow of the completed operation

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high. On rst: busy=0, done=0, sum=0, cout=0, ovf=0; internal shift registers, digit counter and carry are cleared.
- States:
  - IDLE (busy=0): if start=1 on an edge, capture the operands and enter RUN.
    - A register = a.
    - B register = b when sub=0; ~b when sub=1.
    - Carry register = cin when sub=0; ~cin when sub=1.
    - Digit counter = 0.
  - RUN (busy=1): each edge, add the low DIGIT bits of A, B and the carry register.
    - Shift the DIGIT-bit digit result into the top of an internal result shift register (shift right by DIGIT).
    - Shift A and B right by DIGIT.
    - Update the carry register; increment the counter.
    - On the edge that processes digit NDIG-1:
      - Copy the completed result into sum.
      - Set cout = final carry.
      - Set ovf = (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1).
      - Assert done=1 and set busy=0; return to IDLE.
- Latency: if start is accepted at edge E0, done=1 and the new sum are visible after edge E_NDIG. busy is high for exactly NDIG cycles. With DIGIT=WIDTH, the result appears 1 cycle after start.
- done is high for exactly one cycle and falls on the following edge unless a new operation completes on that edge, which is impossible when NDIG>=1 after acceptance.
- start while busy=1 is ignored; it is not queued. Changing a/b/cin/sub while busy has no effect.
- start=1 in the cycle done=1 (busy=0) is accepted: a back-to-back operation begins. sum/cout/ovf keep the previous result until the new done.
- sum, cout and ovf change only on a done edge or on reset, never mid-operation.
- rst during RUN aborts the operation: no done pulse, and all outputs are cleared on that edge.
- Arithmetic: sum = (a + b + cin) mod 2^WIDTH for add; (a - b - cin) mod 2^WIDTH for sub. {cout,sum} equals the full (WIDTH+1)-bit sum of A, the B register and the initial carry.

Test Plan:
- WIDTH=64, DIGIT=8, add: a=0xFFFFFFFFFFFFFFFF, b=1, cin=0 -> sum=0, cout=1, ovf=0; done exactly 8 cycles after the start edge; busy high for 8 cycles.
- Add with signed overflow: a=0x7FFFFFFFFFFFFFFF, b=1, cin=0 -> sum=0x8000000000000000, cout=0, ovf=1.
- Subtract:
  - a=5, b=7, cin=0 -> sum=0xFFFFFFFFFFFFFFFE, cout=0, ovf=0.
  - a=0x8000000000000000, b=1, cin=0 -> sum=0x7FFFFFFFFFFFFFFF, cout=1, ovf=1.
  - a=10, b=3, cin=1 -> sum=6, cout=1.
- Handshake:
  - Hold start=1 continuously with alternating operands -> each operation completes in 8 cycles; the next start is accepted in the done cycle; starts while busy are ignored.
  - Previous sum is held stable until the next done.
- Reset mid-operation: assert rst at the 4th RUN cycle -> next edge busy=0, done=0, sum=0, cout=0, ovf=0; no done pulse follows. A fresh start then completes normally.
- Parameter sweep: WIDTH=16 with DIGIT=1, 4 and 16 -> latency 16, 4 and 1 cycles. 1000 random a/b/cin/sub per configuration match a behavioural (WIDTH+1)-bit model for sum, cout and ovf.
